// File: rtl/note_lane_gen_if.sv
// Playfield bus between the note generator and its consumers (checker, renderer).
// Latency: none, plain wires grouped for port convenience.
// Backpressure: none; run/pause is the enable line, clears are one-cycle pulses.
interface note_lane_gen_if;
    logic       enable;
    logic       clear1;
    logic       clear2;
    logic [9:0] block1_top;
    logic [9:0] block1_bot;
    logic [9:0] block2_top;
    logic [9:0] block2_bot;
    logic       block1_vis;
    logic       block2_vis;
    logic       spawn1;
    logic       spawn2;
    logic       miss1;
    logic       miss2;

    // Controller / consumer side: drives run/pause and hit clears, observes blocks.
    modport master (
        output enable, clear1, clear2,
        input  block1_top, block1_bot, block2_top, block2_bot,
        input  block1_vis, block2_vis, spawn1, spawn2, miss1, miss2
    );

    // Generator side.
    modport slave (
        input  enable, clear1, clear2,
        output block1_top, block1_bot, block2_top, block2_bot,
        output block1_vis, block2_vis, spawn1, spawn2, miss1, miss2
    );
endinterface

// File: rtl/note_lane_gen.sv
// Two-lane falling-note generator: LFSR-spaced spawns, fixed-rate scroll, miss/hit retire.
// Latency: every output is registered, one cycle after the tick or clear that causes it.
// Backpressure: enable low freezes all state and outputs exactly; pulses are suppressed.
module note_lane_gen #(
    parameter int          TICK_DIV  = 100000,
    parameter int          SPEED     = 2,
    parameter int          BLOCK_H   = 40,
    parameter int          SCREEN_H  = 720,
    parameter int          GAP_MIN   = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset,
    note_lane_gen_if.slave  bus
);
    localparam int CW = $clog2(TICK_DIV);

    typedef enum logic {
        S_WAIT = 1'b0,
        S_FALL = 1'b1
    } lane_state_t;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          tick;

    lane_state_t   state_q [2];
    lane_state_t   state_d [2];
    logic [7:0]    gap_q   [2];
    logic [7:0]    gap_d   [2];
    logic [9:0]    bot_q   [2];
    logic [9:0]    bot_d   [2];
    logic [9:0]    top_q   [2];
    logic [9:0]    top_d   [2];
    logic [10:0]   nb      [2];
    logic [7:0]    reload  [2];
    logic [1:0]    vis_q, vis_d;
    logic [1:0]    spawn_q, spawn_d;
    logic [1:0]    miss_q, miss_d;
    logic [1:0]    clear;

    assign clear     = {bus.clear2, bus.clear1};
    // Lanes draw their gaps from disjoint LFSR bytes so they drift apart.
    assign reload[0] = 8'(GAP_MIN) + {2'b00, lfsr_q[5:0]};
    assign reload[1] = 8'(GAP_MIN) + {2'b00, lfsr_q[13:8]};
    assign tick      = bus.enable && (cnt_q == CW'(TICK_DIV - 1));

    // Scroll-step divider and free-running LFSR, both frozen while paused.
    always_comb begin
        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        if (bus.enable) begin
            cnt_d  = tick ? '0 : cnt_q + CW'(1);
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Per-lane WAIT/FALL next state; clear outranks an exit tick so a hit never misses.
    always_comb begin
        spawn_d = '0;
        miss_d  = '0;
        vis_d   = vis_q;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            gap_d[i]   = gap_q[i];
            bot_d[i]   = bot_q[i];
            top_d[i]   = top_q[i];
            nb[i]      = {1'b0, bot_q[i]} + 11'(SPEED);
            if (bus.enable) begin
                case (state_q[i])
                    S_WAIT: begin
                        if (tick) begin
                            if (gap_q[i] == 8'd0) begin
                                state_d[i] = S_FALL;
                                bot_d[i]   = '0;
                                top_d[i]   = '0;
                                vis_d[i]   = 1'b1;
                                spawn_d[i] = 1'b1;
                            end else begin
                                gap_d[i] = gap_q[i] - 8'd1;
                            end
                        end
                    end
                    S_FALL: begin
                        if (clear[i]) begin
                            state_d[i] = S_WAIT;
                            bot_d[i]   = '0;
                            top_d[i]   = '0;
                            vis_d[i]   = 1'b0;
                            gap_d[i]   = reload[i];
                        end else if (tick) begin
                            if (nb[i] >= 11'(SCREEN_H)) begin
                                state_d[i] = S_WAIT;
                                bot_d[i]   = '0;
                                top_d[i]   = '0;
                                vis_d[i]   = 1'b0;
                                miss_d[i]  = 1'b1;
                                gap_d[i]   = reload[i];
                            end else begin
                                bot_d[i] = nb[i][9:0];
                                // Top clamps at 0 while the block is still entering.
                                top_d[i] = (nb[i] >= 11'(BLOCK_H)) ? 10'(nb[i] - 11'(BLOCK_H)) : 10'd0;
                            end
                        end
                    end
                    default: state_d[i] = S_WAIT;
                endcase
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            lfsr_q  <= LFSR_SEED;
            vis_q   <= '0;
            spawn_q <= '0;
            miss_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= S_WAIT;
                gap_q[i]   <= 8'(GAP_MIN);
                bot_q[i]   <= '0;
                top_q[i]   <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            vis_q   <= vis_d;
            spawn_q <= spawn_d;
            miss_q  <= miss_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                gap_q[i]   <= gap_d[i];
                bot_q[i]   <= bot_d[i];
                top_q[i]   <= top_d[i];
            end
        end
    end

    assign bus.block1_top = top_q[0];
    assign bus.block1_bot = bot_q[0];
    assign bus.block2_top = top_q[1];
    assign bus.block2_bot = bot_q[1];
    assign bus.block1_vis = vis_q[0];
    assign bus.block2_vis = vis_q[1];
    assign bus.spawn1     = spawn_q[0];
    assign bus.spawn2     = spawn_q[1];
    assign bus.miss1      = miss_q[0];
    assign bus.miss2      = miss_q[1];
endmodule

// File: doc/note_lane_gen.md
# note_lane_gen

Two-lane falling-note generator for the rhythm game playfield. It spawns one block per lane at pseudo-random intervals and scrolls each block down the 720-line screen at a fixed pixel rate. It drives the `blockN_top`/`blockN_bot` positions consumed by the hit-line checker and the video renderer. It emits a miss pulse when a block leaves the screen unhit, and retires a block early when the checker reports a hit.

## Interface
- `TICK_DIV`, 100000: clock cycles per scroll step; must be ≥2.
- `SPEED`, 2: pixels the block bottom advances per step; 1..16.
- `BLOCK_H`, 40: block height in pixels.
- `SCREEN_H`, 720: bottom edge; a block exits when its bottom would reach this value.
- `GAP_MIN`, 3: minimum idle steps between blocks in a lane.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; overrides all other inputs.
- `enable` in 1: run/pause. When low, the tick counter, LFSR, FSMs and all outputs hold, and no pulses are emitted.
- `clear1`, `clear2` in 1: hit-retire pulse from the hit-line checker, one per lane.
- `block1_top`, `block1_bot`, `block2_top`, `block2_bot` out 10: registered block edges in pixels; both are 0 while the lane is idle.
- `block1_vis`, `block2_vis` out 1: the lane block is on screen.
- `spawn1`, `spawn2` out 1: one-cycle pulse when a block spawns.
- `miss1`, `miss2` out 1: one-cycle pulse when a block exits unhit.

## Operation
- **Tick divider:** counter runs 0..`TICK_DIV`-1 while `enable` is high. The internal `tick` is asserted in the cycle where count = `TICK_DIV`-1; the counter then wraps to 0.
- **LFSR:** 16-bit Fibonacci, taps 16,14,13,11. Shifts every enabled cycle, not only on ticks.
- **Per-lane FSM:** two independent copies, each with states WAIT and FALL.
- **WAIT:**
  - On a tick with gap = 0: enter FALL, bot ← 0, top ← 0, vis ← 1, spawn pulse.
  - On a tick with gap > 0: gap ← gap-1.
- **FALL:** on each tick, compute nb = bot + `SPEED` at 11 bits.
  - If nb ≥ `SCREEN_H`: enter WAIT, bot ← 0, top ← 0, vis ← 0, miss pulse, reload gap.
  - Otherwise: bot ← nb, and top ← (nb ≥ `BLOCK_H`) ? nb-`BLOCK_H` : 0 (saturating).
- **Gap reload on entering WAIT:** `GAP_MIN` + lfsr[5:0] for lane 1, `GAP_MIN` + lfsr[13:8] for lane 2. Sampled from the current LFSR register value.
- **clear:**
  - In FALL: enter WAIT, zero the outputs, vis ← 0, reload gap. No miss pulse.
  - In WAIT: ignored.
- **Simultaneous events:**
  - clear and an exit tick in the same cycle: clear wins, no miss.
  - clear and a spawn tick while in WAIT: spawn proceeds.
  - The two lanes may spawn, miss or clear in the same cycle independently.
- **Idle position:** a lane in WAIT reports bot = 0, which is never inside the 600..649 hit window.

## Timing
- **Reset values:**
  - Outputs: all positions 0, vis 0, spawn 0, miss 0.
  - Internal: both FSMs in WAIT with gap = `GAP_MIN`; tick counter 0; LFSR = `LFSR_SEED`.
- **Output registration:** all outputs are registered. A position, vis or pulse change is visible the cycle after the tick or clear that caused it.
- **First tick:** with `enable` held high from the first cycle after reset deasserts, the first tick falls on enabled cycle `TICK_DIV`.
- **Spawn:** occurs on tick `GAP_MIN`+1 after reset.
- **Lifetime:** a spawned block takes ceil(`SCREEN_H`/`SPEED`) ticks to exit. The miss occurs on that tick.
- **Clear latency:** one cycle from the `clear` edge to vis = 0.
- **Pulse width:** spawn and miss are exactly one cycle, even when `TICK_DIV` = 2.
- **Reset mid-fall:** takes effect next edge; a block in flight vanishes with no miss pulse.
- **enable low mid-operation:** everything freezes exactly. Raising `enable` again resumes the same tick phase.

## Test plan
- **Spawn and scroll:** `TICK_DIV`=4, `SPEED`=2, `GAP_MIN`=3, enable high after reset.
  - spawn1 and spawn2 pulse together one cycle after tick 4 (enabled cycle 16).
  - After 300 further ticks, block1_bot = 600 and block1_top = 560.
- **Miss:** no clears.
  - Bottom sequence is 0,2,…,718; on the 360th tick after spawn, miss1 pulses for one cycle.
  - block1_vis → 0 and block1_bot → 0.
  - The next spawn follows after reloaded gap + 1 ticks, with gap = 3 + lfsr[5:0] at exit.
- **Hit retire:** pulse clear1 when block1_bot = 610.
  - Next cycle: vis1 = 0, bot1 = 0, no miss1.
  - Lane 2 continues unaffected.
- **Clear on exit tick:** assert clear2 in the cycle of the exit tick (bot2 = 718).
  - miss2 stays 0; the lane returns to WAIT.
- **Pause:** drop `enable` for 50 cycles mid-fall.
  - Positions, LFSR and tick counter are unchanged; no pulses.
  - Resume yields the same trace as an unpaused run shifted by 50 cycles.
- **Reset mid-operation:** assert `reset` with both lanes falling.
  - Next cycle: all outputs 0, no miss pulses.
  - The post-reset spawn schedule is identical to the first run.
